seq_pc_controller: RTL and testbench

- Sequencing controller for the SEQ Y86-64 fetch datapath. Owns the architectural PC register and drives the fetch stage one instruction at a time.
- Waits for the back end (decode/execute/memory/writeback) to signal completion, then selects the next PC using Y86 new-PC rules.
- Tracks processor status (AOK/HLT/ADR/INS) and stops the machine on halt, fault or an instruction budget.
- Sits between the fetch stage and the top-level SEQ processor. It replaces the hand-driven "pc = valP" stepping used in unit benches.

---
 rtl/seq_pkg.sv | 22 ++
 rtl/seq_next_pc.sv | 22 ++
 rtl/seq_pc_controller.sv | 114 +++++++++++
 tb/tb_seq_pc_controller.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared encodings for the SEQ sequencing controller
package seq_pkg;

  // Processor status as seen on the 2-bit stat bus
  localparam logic [1:0] STAT_AOK = 2'b01;
  localparam logic [1:0] STAT_HLT = 2'b10;
  localparam logic [1:0] STAT_ADR = 2'b11;
  localparam logic [1:0] STAT_INS = 2'b00;

  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_STOP
  } seq_state_t;

endpackage

// File: rtl/seq_next_pc.sv
// rtl/seq_next_pc.sv - combinational Y86-64 new-PC selector
module seq_next_pc
  import seq_pkg::*;
(
  input  logic [3:0]  i_icode,
  input  logic        i_cnd,
  input  logic [63:0] i_valc,
  input  logic [63:0] i_valm,
  input  logic [63:0] i_valp,
  output logic [63:0] o_new_pc
);

  always_comb begin
    o_new_pc = i_valp;
    if (i_icode == I_CALL || (i_icode == I_JXX && i_cnd)) begin
      o_new_pc = i_valc;
    end else if (i_icode == I_RET) begin
      o_new_pc = i_valm;
    end
  end

endmodule

// File: rtl/seq_pc_controller.sv
// rtl/seq_pc_controller.sv - SEQ fetch sequencer: PC register, status and retire counter
module seq_pc_controller
  import seq_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter logic [31:0] MAX_INSTR = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic        imem_error,
  input  logic        instr_valid,
  input  logic        halt,
  input  logic        cnd,
  input  logic [63:0] valM,
  input  logic        dmem_error,
  input  logic        step_done,
  output logic [63:0] pc,
  output logic        fetch_en,
  output logic        busy,
  output logic [1:0]  stat,
  output logic [31:0] instr_count
);

  seq_state_t  r_state, w_state_nxt;
  logic [63:0] r_pc, w_pc_nxt;
  logic [31:0] r_count, w_count_nxt;
  logic [1:0]  r_stat, w_stat_nxt;
  logic [63:0] w_new_pc;
  logic [31:0] w_count_inc;
  logic        w_budget_hit;
  logic        w_unused_ifun;

  assign w_unused_ifun = ^ifun;

  seq_next_pc u_next_pc (
    .i_icode  (icode),
    .i_cnd    (cnd),
    .i_valc   (valC),
    .i_valm   (valM),
    .i_valp   (valP),
    .o_new_pc (w_new_pc)
  );

  // Counter sticks at all-ones rather than wrapping
  assign w_count_inc  = (r_count == 32'hFFFF_FFFF) ? r_count : r_count + 32'd1;
  assign w_budget_hit = (MAX_INSTR != 32'd0) && (w_count_inc == MAX_INSTR);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_count <= 32'd0;
      r_stat  <= STAT_AOK;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_count <= w_count_nxt;
      r_stat  <= w_stat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_count_nxt = r_count;
    w_stat_nxt  = r_stat;
    case (r_state)
      ST_IDLE, ST_STOP: begin
        if (start) begin
          w_state_nxt = ST_ISSUE;
          w_pc_nxt    = RESET_PC;
          w_count_nxt = 32'd0;
          w_stat_nxt  = STAT_AOK;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        // Faults and halt leave pc on the offending instruction
        if (step_done) begin
          if (imem_error) begin
            w_stat_nxt  = STAT_ADR;
            w_state_nxt = ST_STOP;
          end else if (!instr_valid) begin
            w_stat_nxt  = STAT_INS;
            w_state_nxt = ST_STOP;
          end else if (dmem_error) begin
            w_stat_nxt  = STAT_ADR;
            w_state_nxt = ST_STOP;
          end else if (halt) begin
            w_stat_nxt  = STAT_HLT;
            w_state_nxt = ST_STOP;
          end else begin
            w_count_nxt = w_count_inc;
            w_pc_nxt    = w_new_pc;
            w_state_nxt = w_budget_hit ? ST_STOP : ST_ISSUE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign pc          = r_pc;
  assign fetch_en    = (r_state == ST_ISSUE);
  assign busy        = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
  assign stat        = r_stat;
  assign instr_count = r_count;

endmodule

// File: tb/tb_seq_pc_controller.sv
// tb/tb_seq_pc_controller.sv - self-checking bench for seq_pc_controller
module tb_seq_pc_controller;

  localparam logic [1:0] AOK = 2'b01;
  localparam logic [1:0] HLT = 2'b10;
  localparam logic [1:0] ADR = 2'b11;
  localparam logic [1:0] INS = 2'b00;

  logic clk = 1'b0;
  logic reset, start, cnd, imem_error, instr_valid, halt, dmem_error, step_done;
  logic [3:0] icode, ifun;
  logic [63:0] valC, valP, valM;

  logic [63:0] pc, b_pc;
  logic fetch_en, busy, b_fetch_en, b_busy;
  logic [1:0] stat, b_stat;
  logic [31:0] instr_count, b_count;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_pc_controller dut (
    .clk(clk), .reset(reset), .start(start), .icode(icode), .ifun(ifun),
    .valC(valC), .valP(valP), .imem_error(imem_error), .instr_valid(instr_valid),
    .halt(halt), .cnd(cnd), .valM(valM), .dmem_error(dmem_error),
    .step_done(step_done), .pc(pc), .fetch_en(fetch_en), .busy(busy),
    .stat(stat), .instr_count(instr_count)
  );

  seq_pc_controller #(.RESET_PC(64'd0), .MAX_INSTR(32'd3)) dut_b (
    .clk(clk), .reset(reset), .start(start), .icode(icode), .ifun(ifun),
    .valC(valC), .valP(valP), .imem_error(imem_error), .instr_valid(instr_valid),
    .halt(halt), .cnd(cnd), .valM(valM), .dmem_error(dmem_error),
    .step_done(step_done), .pc(b_pc), .fetch_en(b_fetch_en), .busy(b_busy),
    .stat(b_stat), .instr_count(b_count)
  );

  typedef struct {
    logic [3:0]  ic;
    logic        c;
    logic [63:0] vc;
    logic [63:0] vp;
    logic [63:0] vm;
    logic        im;
    logic        iv;
    logic        dm;
    logic        h;
    logic [63:0] exp_pc;
    logic [1:0]  exp_stat;
    logic        exp_busy;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    step_done = 1'b0; imem_error = 1'b0; instr_valid = 1'b1;
    dmem_error = 1'b0; halt = 1'b0; start = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_fetch(input string name);
    int k = 0;
    while (fetch_en !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check({name, " fetch_en"}, {63'd0, fetch_en}, 64'd1);
  endtask

  // Entered with the DUT in ISSUE; returns one tick after the commit edge
  task automatic commit(input logic [3:0] ic, input logic c, input logic [63:0] vc,
                        input logic [63:0] vp, input logic [63:0] vm, input logic im,
                        input logic iv, input logic dm, input logic h,
                        input int hold, input bit noise);
    if (noise) begin
      step_done = 1'b1; imem_error = 1'b1;
    end
    tick();
    step_done = 1'b0; imem_error = 1'b0;
    check("wait fetch_en", {63'd0, fetch_en}, 64'd0);
    check("wait busy", {63'd0, busy}, 64'd1);
    for (int i = 0; i < hold; i++) begin
      start = noise ? 1'(($urandom % 2)) : 1'b0;
      tick();
    end
    icode = ic; ifun = 4'($urandom); cnd = c; valC = vc; valP = vp; valM = vm;
    imem_error = im; instr_valid = iv; dmem_error = dm; halt = h;
    start = noise ? 1'(($urandom % 2)) : 1'b0;
    step_done = 1'b1;
    tick();
    idle_inputs();
  endtask

  function automatic logic [63:0] ref_next_pc(input int ic, input bit c, input logic [63:0] vc,
                                              input logic [63:0] vp, input logic [63:0] vm);
    if (ic == 8) return vc;
    if (ic == 7 && c) return vc;
    if (ic == 9) return vm;
    return vp;
  endfunction

  logic [63:0] m_pc;
  logic [31:0] m_cnt;
  logic [1:0]  m_stat;
  bit          m_run;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    icode = 4'd0; ifun = 4'd0; cnd = 1'b0; valC = '0; valP = '0; valM = '0;
    idle_inputs();
    reset = 1'b0;

    vecs[0]  = '{4'd7, 1'b1, 64'h100, 64'h9, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h100, AOK, 1'b1, 32'd1};
    vecs[1]  = '{4'd7, 1'b0, 64'h100, 64'h9, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h9, AOK, 1'b1, 32'd1};
    vecs[2]  = '{4'd8, 1'b0, 64'h200, 64'h9, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h200, AOK, 1'b1, 32'd1};
    vecs[3]  = '{4'd9, 1'b1, 64'h300, 64'h1, 64'h13, 1'b0, 1'b1, 1'b0, 1'b0, 64'h13, AOK, 1'b1, 32'd1};
    vecs[4]  = '{4'd3, 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, AOK, 1'b1, 32'd1};
    vecs[5]  = '{4'd3, 1'b0, 64'h0, 64'hA, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, ADR, 1'b0, 32'd0};
    vecs[6]  = '{4'd3, 1'b0, 64'h0, 64'hA, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, INS, 1'b0, 32'd0};
    vecs[7]  = '{4'd5, 1'b0, 64'h0, 64'hA, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, ADR, 1'b0, 32'd0};
    vecs[8]  = '{4'd0, 1'b0, 64'h0, 64'h1, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0, HLT, 1'b0, 32'd0};
    vecs[9]  = '{4'd5, 1'b0, 64'h0, 64'hA, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0, INS, 1'b0, 32'd0};
    vecs[10] = '{4'd6, 1'b1, 64'h500, 64'h2, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h2, AOK, 1'b1, 32'd1};

    // Reset state
    do_reset();
    check("reset pc", pc, 64'd0);
    check("reset fetch_en", {63'd0, fetch_en}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset stat", {62'd0, stat}, {62'd0, AOK});
    check("reset count", {32'd0, instr_count}, 64'd0);
    tick();
    check("idle hold busy", {63'd0, busy}, 64'd0);

    // Straight-line irmovq stepping, fetch_en every second cycle
    start_pulse();
    check("first fetch pc", pc, 64'd0);
    check("first fetch_en", {63'd0, fetch_en}, 64'd1);
    for (int k = 1; k <= 4; k++) begin
      commit(4'd3, 1'b0, 64'd0, 64'(10 * k), 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      check($sformatf("line pc%0d", k), pc, 64'(10 * k));
      check($sformatf("line fetch_en%0d", k), {63'd0, fetch_en}, 64'd1);
    end
    check("line count", {32'd0, instr_count}, 64'd4);

    // Table-driven single commits from a fresh start
    for (int i = 0; i < 11; i++) begin
      do_reset();
      start_pulse();
      commit(vecs[i].ic, vecs[i].c, vecs[i].vc, vecs[i].vp, vecs[i].vm,
             vecs[i].im, vecs[i].iv, vecs[i].dm, vecs[i].h, i % 3, 1'b0);
      check($sformatf("vec%0d pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d stat", i), {62'd0, stat}, {62'd0, vecs[i].exp_stat});
      check($sformatf("vec%0d busy", i), {63'd0, busy}, {63'd0, vecs[i].exp_busy});
      check($sformatf("vec%0d fetch_en", i), {63'd0, fetch_en}, {63'd0, vecs[i].exp_busy});
      check($sformatf("vec%0d count", i), {32'd0, instr_count}, {32'd0, vecs[i].exp_cnt});
    end

    // Halt at 0x20, STOP ignores step_done, restart clears
    do_reset();
    start_pulse();
    commit(4'd7, 1'b1, 64'h20, 64'h9, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    commit(4'd0, 1'b0, 64'd0, 64'h21, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0);
    check("halt stat", {62'd0, stat}, {62'd0, HLT});
    check("halt pc", pc, 64'h20);
    check("halt count", {32'd0, instr_count}, 64'd1);
    check("halt busy", {63'd0, busy}, 64'd0);
    icode = 4'd3; valP = 64'h99; step_done = 1'b1;
    tick();
    tick();
    step_done = 1'b0;
    check("stop hold pc", pc, 64'h20);
    check("stop hold stat", {62'd0, stat}, {62'd0, HLT});
    check("stop hold count", {32'd0, instr_count}, 64'd1);
    check("stop hold fetch_en", {63'd0, fetch_en}, 64'd0);
    start_pulse();
    check("restart pc", pc, 64'd0);
    check("restart stat", {62'd0, stat}, {62'd0, AOK});
    check("restart count", {32'd0, instr_count}, 64'd0);
    check("restart fetch_en", {63'd0, fetch_en}, 64'd1);

    // Instruction budget of three on the second instance
    do_reset();
    start_pulse();
    for (int k = 1; k <= 3; k++) begin
      wait_fetch("budget");
      commit(4'd3, 1'b0, 64'd0, 64'(8 * k), 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
      if (k < 3) check($sformatf("budget busy%0d", k), {63'd0, b_busy}, 64'd1);
    end
    check("budget stopped", {63'd0, b_busy}, 64'd0);
    check("budget stat", {62'd0, b_stat}, {62'd0, AOK});
    check("budget count", {32'd0, b_count}, 64'd3);
    check("budget pc", b_pc, 64'h18);
    check("budget no fetch", {63'd0, b_fetch_en}, 64'd0);
    check("unlimited still busy", {63'd0, busy}, 64'd1);

    // Reset wins over a same-cycle commit in WAIT
    do_reset();
    start_pulse();
    commit(4'd3, 1'b0, 64'd0, 64'h10, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    tick();
    icode = 4'd3; valP = 64'h55; step_done = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst wait pc", pc, 64'd0);
    check("rst wait count", {32'd0, instr_count}, 64'd0);
    check("rst wait busy", {63'd0, busy}, 64'd0);
    check("rst wait stat", {62'd0, stat}, {62'd0, AOK});
    tick();
    step_done = 1'b0;
    check("idle ignores step_done pc", pc, 64'd0);
    check("idle ignores step_done busy", {63'd0, busy}, 64'd0);

    // Randomised instruction stream against the transaction-level model
    do_reset();
    start_pulse();
    m_pc = 64'd0; m_cnt = 32'd0; m_stat = AOK; m_run = 1'b1;
    for (int n = 0; n < 200; n++) begin
      logic [3:0]  r_ic;
      logic        r_c, r_im, r_iv, r_dm, r_h;
      logic [63:0] r_vc, r_vp, r_vm;
      if (!m_run) begin
        start_pulse();
        m_pc = 64'd0; m_cnt = 32'd0; m_stat = AOK; m_run = 1'b1;
      end
      wait_fetch("rnd");
      check("rnd issue pc", pc, m_pc);
      r_ic = 4'($urandom_range(0, 11));
      r_c  = 1'($urandom % 2);
      r_vc = {$urandom, $urandom};
      r_vp = {$urandom, $urandom};
      r_vm = {$urandom, $urandom};
      r_im = ($urandom % 16) == 0;
      r_iv = ($urandom % 16) != 0;
      r_dm = ($urandom % 16) == 0;
      r_h  = (r_ic == 4'd0);
      commit(r_ic, r_c, r_vc, r_vp, r_vm, r_im, r_iv, r_dm, r_h, $urandom_range(0, 3), 1'b1);
      if (r_im) begin m_stat = ADR; m_run = 1'b0; end
      else if (!r_iv) begin m_stat = INS; m_run = 1'b0; end
      else if (r_dm) begin m_stat = ADR; m_run = 1'b0; end
      else if (r_h) begin m_stat = HLT; m_run = 1'b0; end
      else begin
        m_cnt = m_cnt + 32'd1;
        m_pc = ref_next_pc(int'(r_ic), r_c, r_vc, r_vp, r_vm);
      end
      check($sformatf("rnd%0d pc", n), pc, m_pc);
      check($sformatf("rnd%0d stat", n), {62'd0, stat}, {62'd0, m_stat});
      check($sformatf("rnd%0d count", n), {32'd0, instr_count}, {32'd0, m_cnt});
      check($sformatf("rnd%0d busy", n), {63'd0, busy}, {63'd0, m_run});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
